// File: rtl/clint_timer_pkg.sv
// Shared definitions for the core-local interrupt/timer block: register offsets,
// interrupt bit positions (also used by the CSR unit) and reset values.
package clint_timer_pkg;

  localparam logic [7:0] AddrMsip       = 8'h00;
  localparam logic [7:0] AddrMtimecmpLo = 8'h08;
  localparam logic [7:0] AddrMtimecmpHi = 8'h0C;
  localparam logic [7:0] AddrMtimeLo    = 8'h10;
  localparam logic [7:0] AddrMtimeHi    = 8'h14;

  localparam int unsigned IrqMsip     = 3;
  localparam int unsigned IrqMtip     = 7;
  localparam int unsigned IrqMeip     = 11;
  localparam int unsigned IrqPlatBase = 16;
  localparam int unsigned NumPlatIrq  = 16;

  localparam logic [63:0] MtimecmpRst = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    RegMsip,
    RegCmpLo,
    RegCmpHi,
    RegTimeLo,
    RegTimeHi,
    RegNone
  } reg_sel_e;

  // Word-aligned decode; the two byte-offset bits are don't-care.
  function automatic reg_sel_e reg_decode(input logic [7:0] addr);
    logic [7:0] word_addr;
    word_addr = {addr[7:2], 2'b00};
    case (word_addr)
      AddrMsip:       return RegMsip;
      AddrMtimecmpLo: return RegCmpLo;
      AddrMtimecmpHi: return RegCmpHi;
      AddrMtimeLo:    return RegTimeLo;
      AddrMtimeHi:    return RegTimeHi;
      default:        return RegNone;
    endcase
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop level synchronizer for asynchronous interrupt lines.
module irq_sync #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] sync_q [Stages];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Stages); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < int'(Stages); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[Stages-1];

endmodule

// File: rtl/clint_timer.sv
// Core-local interrupter: prescaled 64-bit mtime, mtimecmp, MSIP and synchronized
// external/platform interrupt levels, merged into a registered interrupt vector.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int unsigned PRESCALE        = 1,
  parameter int unsigned EXT_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [7:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_rvalid,
  output logic [31:0] bus_rdata,
  output logic        bus_err,
  input  logic        ext_meip_i,
  input  logic [15:0] plat_irq_i,
  output logic [31:0] interrupts_o
);

  localparam logic [15:0] PrescMax = 16'(PRESCALE - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] irq_q, irq_d;

  logic        meip_sync;
  logic [15:0] plat_sync;
  reg_sel_e    sel;
  logic        wr;
  logic        tick;

  irq_sync #(
    .Width (1),
    .Stages(EXT_SYNC_STAGES)
  ) u_meip_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ext_meip_i),
    .q    (meip_sync)
  );

  irq_sync #(
    .Width (NumPlatIrq),
    .Stages(EXT_SYNC_STAGES)
  ) u_plat_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (plat_irq_i),
    .q    (plat_sync)
  );

  assign sel  = reg_decode(bus_addr);
  assign wr   = bus_req && bus_we;
  assign tick = (presc_q == PrescMax);

  // Read path always reflects pre-write register contents.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    case (sel)
      RegMsip:   rdata_d = {31'b0, msip_q};
      RegCmpLo:  rdata_d = mtimecmp_q[31:0];
      RegCmpHi:  rdata_d = mtimecmp_q[63:32];
      RegTimeLo: rdata_d = mtime_q[31:0];
      RegTimeHi: rdata_d = mtime_q[63:32];
      default:   err_d   = 1'b1;
    endcase
  end

  // A software write to either mtime half overrides the tick and restarts the prescaler.
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q;
    presc_d    = presc_q;
    if (tick) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      presc_d = presc_q + 16'd1;
    end
    if (wr) begin
      case (sel)
        RegMsip:   msip_d = bus_wdata[0];
        RegCmpLo:  mtimecmp_d[31:0] = bus_wdata;
        RegCmpHi:  mtimecmp_d[63:32] = bus_wdata;
        RegTimeLo: begin
          mtime_d = {mtime_q[63:32], bus_wdata};
          presc_d = '0;
        end
        RegTimeHi: begin
          mtime_d = {bus_wdata, mtime_q[31:0]};
          presc_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    irq_d                               = '0;
    irq_d[IrqMsip]                      = msip_q;
    irq_d[IrqMtip]                      = (mtime_q >= mtimecmp_q);
    irq_d[IrqMeip]                      = meip_sync;
    irq_d[IrqPlatBase +: NumPlatIrq]    = plat_sync;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= MtimecmpRst;
      msip_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      irq_q      <= '0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rvalid_q   <= bus_req;
      rdata_q    <= bus_req ? rdata_d : '0;
      err_q      <= bus_req ? err_d : 1'b0;
      irq_q      <= irq_d;
    end
  end

  assign bus_rvalid   = rvalid_q;
  assign bus_rdata    = rdata_q;
  assign bus_err      = err_q;
  assign interrupts_o = irq_q;

endmodule
